// File: rtl/two_bit_counter.sv
// two_bit_counter: modulo-2^WIDTH up/down counter with enable, synchronous
// parallel load and a combinational terminal-count strobe for cascading.
//
// Optional build macro TWO_BIT_COUNTER_GRAY_EN: out is presented as the
// registered Gray code of the internal binary count, and load_val is taken
// as Gray. The default build (macro undefined) presents plain binary.
module two_bit_counter #(
  parameter int              WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  // Binary count is the architectural state in both builds; tc and the
  // arithmetic always work on it.
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] load_bin;

`ifdef TWO_BIT_COUNTER_GRAY_EN
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // MSB passes through; each lower bit folds in everything above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] gray_q;

  assign load_bin = gray2bin(load_val);

  // Gray image is encoded from the next binary value and flopped, so out
  // carries no decode logic after the register.
  always_ff @(posedge clk) begin
    if (rst) gray_q <= bin2gray(RST_VAL);
    else     gray_q <= bin2gray(bin_nxt);
  end

  assign out = gray_q;
`else
  assign load_bin = load_val;
  assign out      = bin_q;
`endif

  // Next-count selection: load beats enable; otherwise hold.
  always_comb begin
    bin_nxt = bin_q;
    if (load)    bin_nxt = load_bin;
    else if (en) bin_nxt = up_dn ? bin_q + ONE : bin_q - ONE;
  end

  // Count register; reset overrides everything on the same edge.
  always_ff @(posedge clk) begin
    if (rst) bin_q <= RST_VAL;
    else     bin_q <= bin_nxt;
  end

  // Terminal count: asserted when the next enabled step wraps. Not gated by
  // rst; downstream consumers qualify it themselves.
  always_comb begin
    tc = en & ~load & ((up_dn & (bin_q == MAX)) | (~up_dn & (bin_q == '0)));
  end

endmodule

// File: tb/tb_two_bit_counter.sv
// Table-driven bench for two_bit_counter (WIDTH=2). Each vector is driven on
// the falling edge; tc is checked combinationally right after driving, and
// the expected post-edge count is queued and popped one rising edge later.
// Expected values are binary; in the Gray build the bench encodes them.
module tb_two_bit_counter;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [1:0] lv;
    logic [1:0] exp_out;
    logic       chk_tc;
    logic       exp_tc;
  } vec_t;

  typedef struct {
    logic [1:0] exp_out;
    logic       step;
    int         idx;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [1:0] load_val;
  logic [1:0] out;
  logic       tc;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  two_bit_counter dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .tc       (tc)
  );

  always #100 clk = ~clk;

  function automatic logic [1:0] enc(input logic [1:0] b);
`ifdef TWO_BIT_COUNTER_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic void add(input logic r, input logic e, input logic u,
                              input logic l, input logic [1:0] v,
                              input logic [1:0] eo, input logic ct,
                              input logic et);
    vec_t x;
    x.rst = r; x.en = e; x.up_dn = u; x.load = l; x.lv = v;
    x.exp_out = eo; x.chk_tc = ct; x.exp_tc = et;
    vecs.push_back(x);
  endfunction

  // Scoreboard consumer: compare the count one tick after each rising edge.
  logic [1:0] prev_out;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      sb_t s;
      s = sb.pop_front();
      n_vec++;
      if (out !== enc(s.exp_out)) begin
        n_err++;
        $display("FAIL out[v%0d]: got %b want %b", s.idx, out, enc(s.exp_out));
      end
`ifdef TWO_BIT_COUNTER_GRAY_EN
      if (s.step) begin
        n_vec++;
        if ($countones(out ^ prev_out) != 1) begin
          n_err++;
          $display("FAIL gray_1bit[v%0d]: %b -> %b", s.idx, prev_out, out);
        end
      end
`endif
      prev_out = out;
    end
  end

  initial begin
    // Reset edge, then 50 free-running up steps.
    add(1, 1, 1, 0, 2'd0, 2'd0, 0, 0);
    for (int k = 1; k <= 50; k++)
      add(0, 1, 1, 0, 2'd0, 2'(k % 4), 1, ((k - 1) % 4) == 3);
    // Count is 2 here: reset mid-count, then release.
    add(1, 1, 1, 0, 2'd0, 2'd0, 1, 0);
    add(0, 1, 1, 0, 2'd0, 2'd1, 1, 0);
    // Down count from 1: 0,3,2,1 with tc while sitting at 0.
    add(0, 1, 0, 0, 2'd0, 2'd0, 1, 0);
    add(0, 1, 0, 0, 2'd0, 2'd3, 1, 1);
    add(0, 1, 0, 0, 2'd0, 2'd2, 1, 0);
    add(0, 1, 0, 0, 2'd0, 2'd1, 1, 0);
    // Up to 2, hold five edges, re-enable to 3.
    add(0, 1, 1, 0, 2'd0, 2'd2, 1, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 2'd0, 2'd2, 1, 0);
    add(0, 1, 1, 0, 2'd0, 2'd3, 1, 0);
    // Hold at 3: tc masked by en=0.
    add(0, 0, 1, 0, 2'd0, 2'd3, 1, 0);
    // Load beats enable and masks tc; load+rst resolves to reset.
    add(0, 1, 1, 1, 2'd3, 2'd3, 1, 0);
    add(1, 1, 1, 1, 2'd2, 2'd0, 1, 0);
    // Load at 0 going down: no tc, count takes load_val.
    add(0, 1, 0, 1, 2'd1, 2'd1, 1, 0);
    // Reset with en=0.
    add(1, 0, 1, 0, 2'd0, 2'd0, 1, 0);
    // Direction flips take effect on the same edge, tc on both wraps.
    add(0, 1, 0, 0, 2'd0, 2'd3, 1, 1);
    add(0, 1, 1, 0, 2'd0, 2'd0, 1, 1);
    add(0, 1, 1, 0, 2'd0, 2'd1, 1, 0);
    // Load 2 then a load of 3 with rst low, then step up wraps.
    add(0, 0, 0, 1, 2'd2, 2'd2, 1, 0);
    add(0, 0, 0, 1, 2'd3, 2'd3, 1, 0);
    add(0, 1, 1, 0, 2'd0, 2'd0, 1, 1);

    prev_out = 2'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      sb_t s;
      rst      = vecs[i].rst;
      en       = vecs[i].en;
      up_dn    = vecs[i].up_dn;
      load     = vecs[i].load;
      load_val = enc(vecs[i].lv);
      #1;
      if (vecs[i].chk_tc) begin
        n_vec++;
        if (tc !== vecs[i].exp_tc) begin
          n_err++;
          $display("FAIL tc[v%0d]: got %b want %b", i, tc, vecs[i].exp_tc);
        end
      end
      s.exp_out = vecs[i].exp_out;
      s.step    = vecs[i].en & ~vecs[i].load & ~vecs[i].rst & (i > 0) &
                  ~vecs[i-(i>0 ? 1 : 0)].load & ~vecs[i-(i>0 ? 1 : 0)].rst;
      s.idx     = i;
      sb.push_back(s);
      @(negedge clk);
    end

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
